riscv_run_monitor: RTL and testbench
====================================

Name: riscv_run_monitor

Overview:
Parametrised, synthesizable run controller for the single-cycle RISC-V core, replacing hand-timed reset and `$finish` sequencing in benches.
- Sequences the core's reset for a configurable number of cycles.
- Snoops the data-memory write port for a "tohost" completion write.
- Counts run cycles and enforces a timeout.
- Reports a sticky pass/fail/timeout verdict that benches and FPGA builds both consume.

Parameters:
XLEN, 32, width of pc, address and data buses
CNT_W, 32, width of cycle counter
RESET_CYCLES, 4, cycles core_rst_n is held low after rst deasserts; minimum 1
TIMEOUT_CYCLES, 1000, RUN cycles before timeout; 0 disables timeout
TOHOST_ADDR, 32'h0000_1000, word address whose nonzero write ends the run
HANG_CYCLES, 8, consecutive unchanged-pc cycles that count as a hang (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
core_rst_n  output  1  reset to core, active-low
pc  input  XLEN  core program counter
mem_we  input  1  core data-memory write enable
mem_addr  input  XLEN  core data-memory address
mem_wdata  input  XLEN  core data-memory write data
running  output  1  monitor in RUN
done  output  1  run finished, sticky
pass  output  1  tohost write of 1
fail  output  1  tohost write of nonzero value other than 1
timeout  output  1  TIMEOUT_CYCLES elapsed with no verdict
hang  output  1  pc stall detected (tied 0 without the optional feature)
fail_code  output  XLEN  mem_wdata >> 1 captured on fail
cycle_count  output  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- On rst=1:
  - State goes to RESET and all counters clear.
  - core_rst_n=0; running, done, pass, fail, timeout, hang = 0; fail_code=0; cycle_count=0.
- FSM states are RESET, RUN, DONE. All outputs are registered.
- RESET:
  - core_rst_n=0.
  - Reset counter increments each cycle with rst=0.
  - When the counter reaches RESET_CYCLES-1, go to RUN. core_rst_n is therefore low for exactly RESET_CYCLES cycles after rst falls.
- RUN:
  - core_rst_n=1 and running=1.
  - cycle_count increments each cycle and saturates at 2^CNT_W-1.
- Tohost event: mem_we=1, mem_addr==TOHOST_ADDR (full-width compare) and mem_wdata!=0.
  - Next cycle: DONE.
  - If mem_wdata==1: pass=1. Otherwise: fail=1 and fail_code=mem_wdata>>1.
  - Writes of 0 to TOHOST_ADDR are ignored. Writes to any other address are ignored.
- Timeout event: TIMEOUT_CYCLES!=0 and the cycle_count register equals TIMEOUT_CYCLES-1 in RUN.
  - Next cycle: DONE, timeout=1, cycle_count=TIMEOUT_CYCLES.
- Priority when events coincide in one cycle: tohost > hang > timeout. Exactly one verdict bit is ever set.
- Latency: verdict and done assert one cycle after the event cycle. cycle_count includes the event cycle.
- DONE:
  - Sticky until rst.
  - done=1, running=0, cycle_count frozen.
  - core_rst_n stays 1 so core state remains inspectable.
  - mem_* and pc inputs are ignored.
- rst asserted mid-RUN or in DONE: synchronous return to RESET on the next edge, with all outputs at reset values.

Optional Feature:
Macro: RISCV_RUN_MONITOR_HANG_DETECT_EN
- Defined:
  - A hang counter tracks consecutive RUN cycles in which pc equals the previous cycle's pc. It clears on any pc change and on entry to RUN.
  - When the counter reaches HANG_CYCLES-1 with no tohost event in that cycle: next cycle DONE, hang=1. This catches `j .` self-loops.
- Undefined: no hang logic is generated and hang is tied 0.

Decomposition:
- Package riscv_run_monitor_pkg:
  - State encoding constants: RESET=2'd0, RUN=2'd1, DONE=2'd2.
  - Verdict codes: PASS_VAL=1.
  - Default TOHOST_ADDR constant.
- Sub-module sat_counter (parameter W; inputs clk, rst, clr, en; output q): saturating up-counter, instantiated for cycle_count and for the hang counter.

Test Plan:
1. Reset release: rst=1 for 3 cycles then 0, RESET_CYCLES=4 -> core_rst_n=0 for exactly 4 cycles after rst falls, then 1; running=1 on the same edge core_rst_n rises.
2. Pass: in RUN, when cycle_count=9, drive mem_we=1, mem_addr=32'h1000, mem_wdata=1 -> next cycle done=1, pass=1, fail=0, cycle_count=10, then frozen for 20 further cycles.
3. Fail and filtering:
   - Write 0 to 32'h1000 -> ignored.
   - Write 5 to 32'h1004 -> ignored.
   - Write 7 to 32'h1000 -> fail=1, fail_code=3, pass=0.
4. Timeout: TIMEOUT_CYCLES=20, no writes -> timeout=1 and done=1 after exactly 20 RUN cycles, cycle_count=20. With TIMEOUT_CYCLES=0, 5000 cycles -> done=0.
5. Coincidence and mid-run reset:
   - Tohost write of 1 on the timeout cycle -> pass=1, timeout=0.
   - rst=1 while in DONE -> all outputs 0, core_rst_n=0, new 4-cycle reset sequence.
6. Hang (macro defined, HANG_CYCLES=8): hold pc=32'h40 -> hang=1 and done=1 after 8 stalled cycles. A pc change at stall cycle 7 restarts the count. With the macro undefined, hang stays 0.

Source files
------------

// File: rtl/riscv_run_monitor_pkg.sv
// Shared definitions for the RISC-V run monitor: state encoding, verdict values
// and the default tohost address.
package riscv_run_monitor_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } run_state_e;

  localparam int          PASS_VAL            = 1;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/riscv_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; it holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller for the single-cycle RISC-V core: sequences core reset, snoops tohost,
// enforces a timeout. Optional pc-stall detection: RISCV_RUN_MONITOR_HANG_DETECT_EN.
module riscv_run_monitor
  import riscv_run_monitor_pkg::*;
#(
  parameter int               XLEN           = 32,
  parameter int               CNT_W          = 32,
  parameter int               RESET_CYCLES   = 4,
  parameter int               TIMEOUT_CYCLES = 1000,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
  parameter int               HANG_CYCLES    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst_n,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             hang_q, hang_d;
  logic [XLEN-1:0]  fail_code_q, fail_code_d;

  logic tohost_ev;
  logic timeout_ev;
  logic hang_ev;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == RESET),
    .en  (state_q == RUN),
    .q   (cycle_count)
  );

  assign tohost_ev  = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != '0);
  // The counter register holds the number of RUN cycles already completed.
  assign timeout_ev = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);

`ifdef RISCV_RUN_MONITOR_HANG_DETECT_EN
  localparam int                HANG_W    = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_CYCLES - 1);

  logic [XLEN-1:0]   prev_pc_q;
  logic [HANG_W-1:0] stall_cnt;
  logic              pc_stalled;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_q <= '0;
    end else begin
      prev_pc_q <= pc;
    end
  end

  assign pc_stalled = (pc == prev_pc_q);

  // Counts stalled cycles already seen; restarts on any pc change or outside RUN.
  sat_counter #(.W(HANG_W)) u_hang_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state_q != RUN) || !pc_stalled),
    .en  (state_q == RUN),
    .q   (stall_cnt)
  );

  assign hang_ev = pc_stalled && (stall_cnt == HANG_LAST);
`else
  logic unused_pc;

  assign unused_pc = (^pc) ^ (HANG_CYCLES != 0);
  assign hang_ev   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    core_rst_n_d = core_rst_n_q;
    running_d    = running_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    hang_d       = hang_q;
    fail_code_d  = fail_code_q;
    case (state_q)
      RESET: begin
        core_rst_n_d = 1'b0;
        running_d    = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          state_d      = RUN;
          core_rst_n_d = 1'b1;
          running_d    = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (tohost_ev || hang_ev || timeout_ev) begin
          state_d   = DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end
        if (tohost_ev) begin
          if (mem_wdata == XLEN'(PASS_VAL)) begin
            pass_d = 1'b1;
          end else begin
            fail_d      = 1'b1;
            fail_code_d = mem_wdata >> 1;
          end
        end else if (hang_ev) begin
          hang_d = 1'b1;
        end else if (timeout_ev) begin
          timeout_d = 1'b1;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET;
      rst_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      hang_q       <= 1'b0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      running_q    <= running_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      hang_q       <= hang_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign running    = running_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign hang       = hang_q;
  assign fail_code  = fail_code_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench for riscv_run_monitor: one instance with a 20-cycle timeout and one
// with the timeout disabled, both fed the same stimulus.
module tb_riscv_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        pc_hold = 1'b0;

  logic        core_rst_n, running, done, pass, fail, timeout, hang;
  logic [31:0] fail_code, cycle_count;
  logic        nt_core_rst_n, nt_running, nt_done, nt_pass, nt_fail, nt_timeout, nt_hang;
  logic [31:0] nt_fail_code, nt_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_run_monitor #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .core_rst_n(core_rst_n), .pc(pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .running(running), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .hang(hang), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  riscv_run_monitor #(.TIMEOUT_CYCLES(0)) dut_nt (
    .clk(clk), .rst(rst), .core_rst_n(nt_core_rst_n), .pc(pc),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .running(nt_running), .done(nt_done), .pass(nt_pass), .fail(nt_fail),
    .timeout(nt_timeout), .hang(nt_hang), .fail_code(nt_fail_code),
    .cycle_count(nt_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Sample #1 after the rising edge, then advance pc unless it is being held.
  task automatic step();
    @(posedge clk);
    #1;
    if (!pc_hold) pc = pc + 32'd4;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    step();
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".core_rst_n"}, 32'(core_rst_n), 0);
    check({tag, ".running"}, 32'(running), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass), 0);
    check({tag, ".fail"}, 32'(fail), 0);
    check({tag, ".timeout"}, 32'(timeout), 0);
    check({tag, ".hang"}, 32'(hang), 0);
    check({tag, ".fail_code"}, fail_code, 0);
    check({tag, ".cycle_count"}, cycle_count, 0);
  endtask

  task automatic start_run(input string tag);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    check({tag, ".running"}, 32'(running), 1);
    check({tag, ".cycle_count"}, cycle_count, 0);
  endtask

  initial begin
    // 1: reset release
    repeat (3) step();
    check_idle("rst");
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("rel%0d.core_rst_n", i), 32'(core_rst_n), 0);
      check($sformatf("rel%0d.running", i), 32'(running), 0);
    end
    step();
    check("rel4.core_rst_n", 32'(core_rst_n), 1);
    check("rel4.running", 32'(running), 1);
    check("rel4.cycle_count", cycle_count, 0);

    // 2: pass at cycle_count 9, then frozen while later writes are ignored
    repeat (9) step();
    check("pass.pre_count", cycle_count, 9);
    check("pass.pre_done", 32'(done), 0);
    write(32'h1000, 32'd1);
    check("pass.done", 32'(done), 1);
    check("pass.pass", 32'(pass), 1);
    check("pass.fail", 32'(fail), 0);
    check("pass.timeout", 32'(timeout), 0);
    check("pass.running", 32'(running), 0);
    check("pass.cycle_count", cycle_count, 10);
    repeat (20) write(32'h1000, 32'd7);
    check("frozen.pass", 32'(pass), 1);
    check("frozen.fail", 32'(fail), 0);
    check("frozen.cycle_count", cycle_count, 10);
    check("frozen.core_rst_n", 32'(core_rst_n), 1);

    // 3: filtering then fail
    start_run("fail");
    write(32'h1000, 32'd0);
    check("zero_write.done", 32'(done), 0);
    write(32'h1004, 32'd5);
    check("other_addr.done", 32'(done), 0);
    write(32'h1000, 32'd7);
    check("fail.fail", 32'(fail), 1);
    check("fail.pass", 32'(pass), 0);
    check("fail.fail_code", fail_code, 3);
    check("fail.done", 32'(done), 1);
    check("fail.cycle_count", cycle_count, 3);

    // 4: timeout after 20 RUN cycles; disabled-timeout instance keeps running
    start_run("to");
    repeat (19) step();
    check("to.pre_done", 32'(done), 0);
    check("to.pre_count", cycle_count, 19);
    step();
    check("to.timeout", 32'(timeout), 1);
    check("to.done", 32'(done), 1);
    check("to.pass", 32'(pass), 0);
    check("to.running", 32'(running), 0);
    check("to.cycle_count", cycle_count, 20);
    repeat (4980) step();
    check("no_to.done", 32'(nt_done), 0);
    check("no_to.running", 32'(nt_running), 1);
    check("no_to.cycle_count", nt_cycle_count, 5000);
    check("to.frozen_count", cycle_count, 20);

    // 5: tohost beats timeout, then reset from DONE
    start_run("coin");
    repeat (19) step();
    write(32'h1000, 32'd1);
    check("coin.pass", 32'(pass), 1);
    check("coin.timeout", 32'(timeout), 0);
    check("coin.cycle_count", cycle_count, 20);
    rst = 1'b1;
    step();
    check_idle("rst_done");
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("rerel%0d.core_rst_n", i), 32'(core_rst_n), 0);
    end
    step();
    check("rerel4.core_rst_n", 32'(core_rst_n), 1);

    // 6: pc stall detection
`ifdef RISCV_RUN_MONITOR_HANG_DETECT_EN
    pc_hold = 1'b0;
    start_run("hang");
    pc_hold = 1'b1;
    repeat (8) step();
    check("hang.pre_done", 32'(done), 0);
    step();
    check("hang.hang", 32'(hang), 1);
    check("hang.done", 32'(done), 1);
    check("hang.timeout", 32'(timeout), 0);
    check("hang.cycle_count", cycle_count, 9);
    pc_hold = 1'b0;
    start_run("hang2");
    pc_hold = 1'b1;
    repeat (7) step();
    pc = pc + 32'd4;
    repeat (8) step();
    check("hang2.pre_done", 32'(done), 0);
    step();
    check("hang2.hang", 32'(hang), 1);
    check("hang2.done", 32'(done), 1);
`else
    pc_hold = 1'b0;
    start_run("nohang");
    pc_hold = 1'b1;
    repeat (12) step();
    check("nohang.hang", 32'(hang), 0);
    check("nohang.done", 32'(done), 0);
    check("nohang.running", 32'(running), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
